// File: rtl/radix4_div_pkg.sv
// Shared types for the radix-4 SRT divider back end: converter FSM states,
// signed quotient digit encoding and the largest legal digit magnitude.
package radix4_div_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CONV     = 2'd1,
      WAIT_REM = 2'd2,
      OUT      = 2'd3
   } state_e;

   typedef struct packed {
      logic       sign;
      logic [1:0] mag;
   } sdigit_t;

   localparam int DIGIT_MAG_MAX = 2;

endpackage

// File: rtl/radix4_otf_step.sv
// One on-the-fly conversion step: appends a signed radix-4 digit to the Q/QM pair.
// Purely combinational; an out-of-range magnitude is flagged and treated as zero.
module radix4_otf_step
   import radix4_div_pkg::*;
#(
   parameter int QW = 24
)
(
   input  logic [QW-1:0] i_q,
   input  logic [QW-1:0] i_qm,
   input  sdigit_t       i_digit,
   output logic [QW-1:0] o_q_nxt,
   output logic [QW-1:0] o_qm_nxt,
   output logic          o_illegal
);

   logic [1:0] w_mag;

   assign o_illegal = (i_digit.mag > 2'(DIGIT_MAG_MAX));

   always_comb begin
      w_mag    = o_illegal ? 2'd0 : i_digit.mag;
      o_q_nxt  = {i_q[QW-3:0],  2'b00};
      o_qm_nxt = {i_qm[QW-3:0], 2'b11};
      if (w_mag != 2'd0) begin
         if (!i_digit.sign) begin
            o_q_nxt  = {i_q[QW-3:0], w_mag};
            o_qm_nxt = {i_q[QW-3:0], w_mag - 2'd1};
         end else begin
            // Negative digit borrows from QM: low pair is 4+q for Q, 3+q for QM.
            o_q_nxt  = {i_qm[QW-3:0], 2'd0 - w_mag};
            o_qm_nxt = {i_qm[QW-3:0], ~w_mag};
         end
      end
   end

endmodule

// File: rtl/radix4_otf_converter.sv
// Radix-4 SRT digit stream to two's-complement quotient with remainder-sign fixup.
// Latency: start to quo_valid >= QW/2+2 cycles; one digit per digit handshake.
// Backpressure: valid/ready on digit, rem and quo ports; RADIX4_OTF_STICKY_EN adds the inexact flag.
module radix4_otf_converter
   import radix4_div_pkg::*;
#(
   parameter int QW = 24
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          start,
   input  logic          digit_valid,
   output logic          digit_ready,
   input  logic          digit_sign,
   input  logic [1:0]    digit_mag,
   input  logic          rem_valid,
   output logic          rem_ready,
   input  logic          rem_neg,
   input  logic          rem_zero,
   output logic          quo_valid,
   input  logic          quo_ready,
   output logic [QW-1:0] quotient,
   output logic          sticky,
   output logic          err,
   output logic          busy
);

   localparam int ITER  = QW / 2;
   localparam int CNT_W = $clog2(ITER + 1);

   state_e           r_state;
   logic [QW-1:0]    r_q;
   logic [QW-1:0]    r_qm;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic [QW-1:0]    r_quotient;

   sdigit_t          w_digit;
   logic [QW-1:0]    w_q_nxt;
   logic [QW-1:0]    w_qm_nxt;
   logic             w_illegal;
   logic             w_last;

   assign w_digit = {digit_sign, digit_mag};
   assign w_last  = (r_cnt == CNT_W'(ITER - 1));

   radix4_otf_step #(.QW(QW)) u_step (
      .i_q       (r_q),
      .i_qm      (r_qm),
      .i_digit   (w_digit),
      .o_q_nxt   (w_q_nxt),
      .o_qm_nxt  (w_qm_nxt),
      .o_illegal (w_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_q        <= '0;
         r_qm       <= '1;
         r_cnt      <= '0;
         r_err      <= 1'b0;
         r_quotient <= '0;
      end else if (flush) begin
         // Abort keeps the last delivered quotient visible.
         r_state <= IDLE;
         r_q     <= '0;
         r_qm    <= '1;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= CONV;
                  r_q     <= '0;
                  r_qm    <= '1;
                  r_cnt   <= '0;
                  r_err   <= 1'b0;
               end
            end
            CONV: begin
               if (digit_valid) begin
                  r_q   <= w_q_nxt;
                  r_qm  <= w_qm_nxt;
                  r_err <= r_err | w_illegal;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) r_state <= WAIT_REM;
               end
            end
            WAIT_REM: begin
               if (rem_valid) begin
                  r_quotient <= rem_neg ? r_qm : r_q;
                  r_state    <= OUT;
               end
            end
            OUT: begin
               if (quo_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef RADIX4_OTF_STICKY_EN
   logic r_sticky;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
      end else if (flush) begin
         r_sticky <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_sticky <= 1'b0;
      end else if (r_state == WAIT_REM && rem_valid) begin
         r_sticky <= ~rem_zero;
      end
   end

   assign sticky = r_sticky;
`else
   logic w_unused_rem_zero;

   assign w_unused_rem_zero = rem_zero;
   assign sticky            = 1'b0;
`endif

   assign digit_ready = (r_state == CONV);
   assign rem_ready   = (r_state == WAIT_REM);
   assign quo_valid   = (r_state == OUT);
   assign busy        = (r_state != IDLE);
   assign quotient    = r_quotient;
   assign err         = r_err;

endmodule

// File: tb/tb_radix4_otf_converter.sv
// Directed scoreboard bench for radix4_otf_converter at QW=6 (three digits per division).
module tb_radix4_otf_converter;

   localparam int QW = 6;
`ifdef RADIX4_OTF_STICKY_EN
   localparam bit STICKY_ON = 1'b1;
`else
   localparam bit STICKY_ON = 1'b0;
`endif

   // Digit encodings {sign, mag}
   localparam logic [2:0] P2 = 3'b010, P1 = 3'b001, ZZ = 3'b000;
   localparam logic [2:0] N1 = 3'b101, N2 = 3'b110, NZ = 3'b100, IL = 3'b011;

   logic          clk = 1'b0;
   logic          rst_n, flush, start;
   logic          digit_valid, digit_ready, digit_sign;
   logic [1:0]    digit_mag;
   logic          rem_valid, rem_ready, rem_neg, rem_zero;
   logic          quo_valid, quo_ready;
   logic [QW-1:0] quotient;
   logic          sticky, err, busy;

   typedef struct packed {
      logic [QW-1:0] q;
      logic          err;
      logic          sticky;
   } exp_t;

   exp_t q_exp[$];
   int   checks = 0;
   int   errors = 0;
   logic [QW-1:0] last_q;

   always #5 clk = ~clk;

   radix4_otf_converter #(.QW(QW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .start       (start),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .digit_sign  (digit_sign),
      .digit_mag   (digit_mag),
      .rem_valid   (rem_valid),
      .rem_ready   (rem_ready),
      .rem_neg     (rem_neg),
      .rem_zero    (rem_zero),
      .quo_valid   (quo_valid),
      .quo_ready   (quo_ready),
      .quotient    (quotient),
      .sticky      (sticky),
      .err         (err),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: quotient must match the head expectation for every OUT cycle.
   always @(negedge clk) begin
      if (rst_n && quo_valid) begin
         if (q_exp.size() == 0) begin
            chk("unexpected_quo_valid", 32'd1, 32'd0);
         end else begin
            chk("quotient", 32'(quotient), 32'(q_exp[0].q));
            if (quo_ready) begin
               chk("err", 32'(err), 32'(q_exp[0].err));
               chk("sticky", 32'(sticky), 32'(q_exp[0].sticky));
               void'(q_exp.pop_front());
            end
         end
      end
   end

   task automatic push_exp(input logic [QW-1:0] eq, input logic ee, input logic rz);
      exp_t e;
      e.q      = eq;
      e.err    = ee;
      e.sticky = STICKY_ON ? ~rz : 1'b0;
      q_exp.push_back(e);
      last_q = eq;
   endtask

   task automatic run(input logic [8:0] ds, input logic rn, input logic rz,
                      input int hold, input bit gap,
                      input logic [QW-1:0] eq, input logic ee);
      int n;
      push_exp(eq, ee, rz);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("err_clr_on_start", 32'(err), 32'd0);
      for (int i = 0; i < 3; i++) begin
         if (gap && i > 0) begin
            digit_valid = 1'b0;
            tick();
         end
         digit_valid = 1'b1;
         {digit_sign, digit_mag} = ds[8-3*i -: 3];
         n = 0;
         while (!digit_ready && n < 50) begin tick(); n++; end
         if (!digit_ready) chk("digit_ready_timeout", 32'd1, 32'd0);
         tick();
      end
      digit_valid = 1'b0;
      chk("rem_ready_after_last", 32'(rem_ready), 32'd1);
      rem_valid = 1'b1;
      rem_neg   = rn;
      rem_zero  = rz;
      n = 0;
      while (!rem_ready && n < 50) begin tick(); n++; end
      if (!rem_ready) chk("rem_ready_timeout", 32'd1, 32'd0);
      tick();
      rem_valid = 1'b0;
      chk("quo_valid_after_rem", 32'(quo_valid), 32'd1);
      for (int h = 0; h < hold; h++) begin
         start = (h == 1);
         tick();
         chk("quo_valid_held", 32'(quo_valid), 32'd1);
      end
      start     = 1'b0;
      quo_ready = 1'b1;
      n = 0;
      while (!quo_valid && n < 50) begin tick(); n++; end
      if (!quo_valid) chk("quo_valid_timeout", 32'd1, 32'd0);
      tick();
      quo_ready = 1'b0;
      chk("idle_after_out", 32'(busy), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_digit_ready"}, 32'(digit_ready), 32'd0);
      chk({tag, "_rem_ready"},   32'(rem_ready),   32'd0);
      chk({tag, "_quo_valid"},   32'(quo_valid),   32'd0);
      chk({tag, "_quotient"},    32'(quotient),    32'd0);
      chk({tag, "_sticky"},      32'(sticky),      32'd0);
      chk({tag, "_err"},         32'(err),         32'd0);
      chk({tag, "_busy"},        32'(busy),        32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; flush = 1'b0; start = 1'b0;
      digit_valid = 1'b0; digit_sign = 1'b0; digit_mag = 2'd0;
      rem_valid = 1'b0; rem_neg = 1'b0; rem_zero = 1'b1; quo_ready = 1'b0;
      last_q = '0;
      repeat (2) tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      run({P2, N1, P1}, 1'b0, 1'b1, 0, 1'b0, 6'd29, 1'b0);
      run({P2, N1, P1}, 1'b1, 1'b0, 0, 1'b1, 6'd28, 1'b0);
      run({N1, ZZ, ZZ}, 1'b0, 1'b1, 0, 1'b0, 6'd48, 1'b0);
      run({P1, IL, P1}, 1'b0, 1'b0, 0, 1'b0, 6'd17, 1'b1);
      chk("err_held_in_idle", 32'(err), 32'd1);
      run({P2, P2, P2}, 1'b0, 1'b1, 5, 1'b0, 6'd42, 1'b0);
      run({N2, N2, N2}, 1'b0, 1'b1, 0, 1'b1, 6'd22, 1'b0);
      run({NZ, ZZ, P1}, 1'b1, 1'b1, 0, 1'b0, 6'd0,  1'b0);
      run({N2, N2, N2}, 1'b1, 1'b0, 0, 1'b0, 6'd21, 1'b0);
      run({ZZ, ZZ, ZZ}, 1'b1, 1'b1, 0, 1'b0, 6'd63, 1'b0);

      // Back-to-back stream; a digit present with start must not be consumed.
      push_exp(6'd21, 1'b0, 1'b1);
      digit_valid = 1'b1; {digit_sign, digit_mag} = P1;
      rem_valid = 1'b1; rem_neg = 1'b0; rem_zero = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (!quo_valid && n < 50) begin tick(); n++; end
      chk("min_latency_cycles", 32'(n), 32'd5);
      digit_valid = 1'b0; rem_valid = 1'b0;
      quo_ready = 1'b1;
      tick();
      quo_ready = 1'b0;

      // Flush mid-conversion after an illegal digit.
      start = 1'b1;
      tick();
      start = 1'b0;
      digit_valid = 1'b1; {digit_sign, digit_mag} = IL;
      tick();
      {digit_sign, digit_mag} = P1;
      tick();
      digit_valid = 1'b0;
      chk("err_before_flush", 32'(err), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_digit_ready", 32'(digit_ready), 32'd0);
      chk("flush_err", 32'(err), 32'd0);
      chk("flush_keeps_quotient", 32'(quotient), 32'(last_q));
      run({P1, P1, P1}, 1'b0, 1'b1, 0, 1'b0, 6'd21, 1'b0);

      // Asynchronous reset mid-conversion.
      start = 1'b1;
      tick();
      start = 1'b0;
      digit_valid = 1'b1; {digit_sign, digit_mag} = P2;
      repeat (2) tick();
      digit_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      run({P2, P2, P2}, 1'b0, 1'b0, 0, 1'b0, 6'd42, 1'b0);

      repeat (3) tick();
      chk("scoreboard_empty", 32'(q_exp.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
